// File: rtl/multiplier_cell.sv
// Sequential dot-product cell: one multiply-accumulate per clock over a frame.
// MULTIPLIER_CELL_SATURATE_EN selects a saturating 8-bit result instead of wrap.
module multiplier_cell #(
  parameter int MATRIXSIZE = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MATRIXSIZE*8-1:0] a_flat,
  input  logic [MATRIXSIZE*8-1:0] b_flat,
  output logic [7:0]              o,
  output logic                    valid
);

  localparam int IW = (MATRIXSIZE > 1) ? $clog2(MATRIXSIZE) : 1;
  localparam int AW = 16 + $clog2(MATRIXSIZE) + 1;
  localparam logic [IW-1:0] LAST = IW'(MATRIXSIZE - 1);

  logic [IW-1:0] idx;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [7:0]    el_a;
  logic [7:0]    el_b;
  logic [15:0]   prod;
  logic [7:0]    res;
  logic          first;
  logic          last;

  assign first = (idx == '0);
  assign last  = (idx == LAST);
  assign prod  = el_a * el_b;
  assign sum   = (first ? '0 : acc) + AW'(prod);

`ifdef MULTIPLIER_CELL_SATURATE_EN
  assign res = (|sum[AW-1:8]) ? 8'hFF : sum[7:0];
`else
  assign res = sum[7:0];
`endif

  // Element 0 comes from the live bus; the rest from the frame snapshot.
  if (MATRIXSIZE > 1) begin : g_shadow
    localparam int SW = (MATRIXSIZE - 1) * 8;

    logic [SW-1:0] sh_a;
    logic [SW-1:0] sh_b;

    always_ff @(posedge clk) begin
      if (rst) begin
        sh_a <= '0;
        sh_b <= '0;
      end else if (first) begin
        sh_a <= a_flat[MATRIXSIZE*8-1:8];
        sh_b <= b_flat[MATRIXSIZE*8-1:8];
      end
    end

    always_comb begin
      el_a = a_flat[7:0];
      el_b = b_flat[7:0];
      for (int i = 1; i < MATRIXSIZE; i++) begin
        if (idx == IW'(i)) begin
          el_a = sh_a[(i-1)*8 +: 8];
          el_b = sh_b[(i-1)*8 +: 8];
        end
      end
    end
  end else begin : g_single
    assign el_a = a_flat[7:0];
    assign el_b = b_flat[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      acc   <= '0;
      o     <= '0;
      valid <= 1'b0;
    end else if (last) begin
      idx   <= '0;
      acc   <= '0;
      o     <= res;
      valid <= 1'b1;
    end else begin
      idx   <= idx + IW'(1);
      acc   <= sum;
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplier_cell.sv
// Self-checking bench for multiplier_cell: vector table, corner
// sequences and a randomized frame-level reference model.
module tb_multiplier_cell;

  localparam int N = 5;
`ifdef MULTIPLIER_CELL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*8-1:0] a = '0;
  logic [N*8-1:0] b = '0;
  logic [7:0]     o;
  logic           valid;

  logic           rst1 = 1'b1;
  logic [7:0]     a1 = '0;
  logic [7:0]     b1 = '0;
  logic [7:0]     o1;
  logic           valid1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplier_cell #(.MATRIXSIZE(N)) dut (
    .clk(clk), .rst(rst), .a_flat(a), .b_flat(b),
    .o(o), .valid(valid)
  );

  multiplier_cell #(.MATRIXSIZE(1)) dut1 (
    .clk(clk), .rst(rst1), .a_flat(a1), .b_flat(b1),
    .o(o1), .valid(valid1)
  );

  typedef struct {
    logic [N*8-1:0] a;
    logic [N*8-1:0] b;
    int             exp_o;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int final8(input longint s);
    if (SAT) return (s > 255) ? 255 : int'(s);
    return int'(s % 256);
  endfunction

  function automatic longint dot(input logic [N*8-1:0] x,
                                 input logic [N*8-1:0] y);
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += longint'(x[i*8 +: 8]) * longint'(y[i*8 +: 8]);
    return s;
  endfunction

  // Frame-level reference state.
  int             m_pos = 0;
  int             m_o = 0;
  int             m_v = 0;
  logic [N*8-1:0] m_a;
  logic [N*8-1:0] m_b;

  task automatic model_edge();
    if (rst) begin
      m_pos = 0;
      m_o   = 0;
      m_v   = 0;
    end else begin
      if (m_pos == 0) begin
        m_a = a;
        m_b = b;
      end
      m_pos++;
      if (m_pos == N) begin
        m_o   = final8(dot(m_a, m_b));
        m_v   = 1;
        m_pos = 0;
      end else begin
        m_v = 0;
      end
    end
  endtask

  localparam logic [N*8-1:0] DA = {8'd2, 8'd4, 8'd8, 8'd6, 8'd4};
  localparam logic [N*8-1:0] DB = {8'd1, 8'd5, 8'd1, 8'd9, 8'd3};

  initial begin
    tbl[0] = '{DA, DB, 96};
    tbl[1] = '{{N{8'hFF}}, {N{8'hFF}}, SAT ? 255 : 5};
    tbl[2] = '{'0, '0, 0};
    tbl[3] = '{{8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               {8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 35};
    tbl[4] = '{{8'd1, 8'd0, 8'd0, 8'd16, 8'd16},
               {8'd1, 8'd0, 8'd0, 8'd16, 8'd16}, SAT ? 255 : 1};

    step();
    step();
    chk("reset_o", int'(o), 0);
    chk("reset_valid", int'(valid), 0);

    for (int t = 0; t < 5; t++) begin
      a   = tbl[t].a;
      b   = tbl[t].b;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk($sformatf("v%0d_rst_o", t), int'(o), 0);
      for (int e = 1; e <= N; e++) begin
        step();
        if (e < N) chk($sformatf("v%0d_e%0d_valid", t, e), int'(valid), 0);
      end
      chk($sformatf("v%0d_valid", t), int'(valid), 1);
      chk($sformatf("v%0d_o", t), int'(o), tbl[t].exp_o);
      step();
      chk($sformatf("v%0d_pulse_end", t), int'(valid), 0);
      chk($sformatf("v%0d_hold", t), int'(o), tbl[t].exp_o);
      for (int e = 2; e <= N; e++) step();
      chk($sformatf("v%0d_rep_valid", t), int'(valid), 1);
      chk($sformatf("v%0d_rep_o", t), int'(o), tbl[t].exp_o);
    end

    // Input change part-way through a frame.
    a   = DA;
    b   = DB;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    a = '0;
    step();
    step();
    step();
    chk("mid_cur_valid", int'(valid), 1);
    chk("mid_cur_o", int'(o), 96);
    for (int e = 1; e <= N; e++) step();
    chk("mid_next_valid", int'(valid), 1);
    chk("mid_next_o", int'(o), 0);

    // Reset in the middle of a running frame.
    a   = DA;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= N; e++) step();
    chk("rm_first_o", int'(o), 96);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_rst_o", int'(o), 0);
    chk("rm_rst_valid", int'(valid), 0);
    for (int e = 1; e < N; e++) step();
    chk("rm_early_valid", int'(valid), 0);
    step();
    chk("rm_valid", int'(valid), 1);
    chk("rm_o", int'(o), 96);

    // Single-element build.
    a1 = 8'd7;
    b1 = 8'd9;
    step();
    chk("n1_rst_valid", int'(valid1), 0);
    chk("n1_rst_o", int'(o1), 0);
    rst1 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("n1_e%0d_valid", e), int'(valid1), 1);
      chk($sformatf("n1_e%0d_o", e), int'(o1), 63);
    end
    a1 = 8'hFF;
    b1 = 8'hFF;
    step();
    chk("n1_ovf_o", int'(o1), SAT ? 255 : 1);

    // Randomized frames against the reference model.
    rst = 1'b1;
    model_edge();
    step();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) begin
        a = {N{8'hFF}};
        b = {N{8'hFF}};
      end else begin
        for (int i = 0; i < N; i++) begin
          a[i*8 +: 8] = 8'($urandom);
          b[i*8 +: 8] = 8'($urandom);
        end
      end
      model_edge();
      step();
      chk($sformatf("rnd%0d_valid", c), int'(valid), m_v);
      chk($sformatf("rnd%0d_o", c), int'(o), m_o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
